// File: rtl/fp21_normalize.sv
// fp21_normalize: three-stage post-add normalizer for the FP21 format
// (1 sign, 8 exponent with bias 127, 12 fraction).
//   S1: leading-one detect on the raw 15-bit magnitude
//   S2: significand shift and exponent adjust (10-bit signed exponent)
//   S3: round, range check, pack into {sign, exp, frac}
// Build option: define FP21_NORM_ROUND_EN for round-to-nearest-even;
// leave it undefined to truncate. Latency and interface do not change.
// One global advance enable (in_ready) moves every stage together. A stall
// only happens while the output holds a valid beat, so every upstream
// bubble has a valid stage downstream of it and must hold as well.
module fp21_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [14:0] in_mag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [20:0] out_data,
    output logic        out_ovf,
    output logic        out_unf
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 12;
    localparam int unsigned MAG_W  = 15;
    localparam int unsigned SIG_W  = 13;
    localparam int unsigned EXPI_W = 10;
    localparam int unsigned LZ_W   = 4;

    typedef enum logic [1:0] {
        SH_LEFT = 2'd0,
        SH_R1   = 2'd1,
        SH_R2   = 2'd2
    } shift_e;

    // ---------------- stage 1 : leading-one detect ----------------
    logic               s1_valid_q;
    logic               s1_sign_q;
    logic [EXP_W-1:0]   s1_exp_q;
    logic [MAG_W-1:0]   s1_mag_q;
    shift_e             s1_sh_q,  s1_sh_d;
    logic [LZ_W-1:0]    s1_lz_q,  s1_lz_d;

    assign in_ready = ~out_valid | out_ready;

    // Pick the shift direction and the left-shift distance for the hidden one
    always_comb begin
        s1_lz_d = '0;
        for (int i = 0; i < int'(SIG_W); i++) begin
            if (in_mag[i]) s1_lz_d = LZ_W'(int'(SIG_W) - 1 - i);
        end
        if (in_mag[MAG_W-1])      s1_sh_d = SH_R2;
        else if (in_mag[MAG_W-2]) s1_sh_d = SH_R1;
        else                      s1_sh_d = SH_LEFT;
    end

    // Stage 1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mag_q   <= '0;
            s1_sh_q    <= SH_LEFT;
            s1_lz_q    <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= in_sign;
            s1_exp_q   <= in_exp;
            s1_mag_q   <= in_mag;
            s1_sh_q    <= s1_sh_d;
            s1_lz_q    <= s1_lz_d;
        end
    end

    // ---------------- stage 2 : shift and exponent adjust ----------------
    logic                      s2_valid_q;
    logic                      s2_sign_q;
    logic [SIG_W-1:0]          s2_sig_q,  s2_sig_d;
    logic signed [EXPI_W-1:0]  s2_exp_q,  s2_exp_d;
    logic signed [EXPI_W-1:0]  s1_exp_ext_c;
    logic signed [EXPI_W-1:0]  s1_lz_ext_c;
    logic                      round_up_c;

    assign s1_exp_ext_c = EXPI_W'(s1_exp_q);
    assign s1_lz_ext_c  = EXPI_W'(s1_lz_q);

    // Align the hidden one to bit 12; zero magnitude stays zero
    always_comb begin
        s2_sig_d = s1_mag_q[SIG_W-1:0];
        s2_exp_d = s1_exp_ext_c;
        case (s1_sh_q)
            SH_R2: begin
                s2_sig_d = s1_mag_q[MAG_W-1:2];
                s2_exp_d = s1_exp_ext_c + 10'sd2;
            end
            SH_R1: begin
                s2_sig_d = s1_mag_q[MAG_W-2:1];
                s2_exp_d = s1_exp_ext_c + 10'sd1;
            end
            default: begin
                s2_sig_d = SIG_W'(s1_mag_q[SIG_W-1:0] << s1_lz_q);
                s2_exp_d = s1_exp_ext_c - s1_lz_ext_c;
            end
        endcase
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_sig_q   <= '0;
            s2_exp_q   <= '0;
        end else if (in_ready) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_sig_q   <= s2_sig_d;
            s2_exp_q   <= s2_exp_d;
        end
    end

`ifdef FP21_NORM_ROUND_EN
    logic s2_guard_q,  s2_guard_d;
    logic s2_sticky_q, s2_sticky_d;

    // Bits dropped by a right shift; left shifts lose nothing
    always_comb begin
        s2_guard_d  = 1'b0;
        s2_sticky_d = 1'b0;
        case (s1_sh_q)
            SH_R2: begin
                s2_guard_d  = s1_mag_q[1];
                s2_sticky_d = s1_mag_q[0];
            end
            SH_R1:   s2_guard_d = s1_mag_q[0];
            default: ;
        endcase
    end

    // Guard/sticky travel alongside the stage 2 significand
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
        end else if (in_ready) begin
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
        end
    end

    // Nearest, ties to even
    assign round_up_c = s2_guard_q & (s2_sticky_q | s2_sig_q[0]);
`else
    // Truncation: dropped bits are ignored
    assign round_up_c = 1'b0;
`endif

    // ---------------- stage 3 : round, range check, pack ----------------
    logic [SIG_W:0]            sum_c;
    logic signed [EXPI_W-1:0]  exp_r_c;
    logic                      is_zero_c;
    logic [20:0]               out_data_d;
    logic                      out_ovf_d, out_unf_d;
    logic                      out_valid_q;
    logic [20:0]               out_data_q;
    logic                      out_ovf_q, out_unf_q;

    assign sum_c     = {1'b0, s2_sig_q} + (SIG_W+1)'(round_up_c);
    assign exp_r_c   = s2_exp_q + (sum_c[SIG_W] ? 10'sd1 : 10'sd0);
    // A normalized significand always has bit 12 (or the carry) set
    assign is_zero_c = ~(sum_c[SIG_W] | sum_c[SIG_W-1]);

    // Pack the rounded result and saturate/flush out-of-range exponents
    always_comb begin
        out_data_d = {s2_sign_q, exp_r_c[EXP_W-1:0], sum_c[FRAC_W-1:0]};
        out_ovf_d  = 1'b0;
        out_unf_d  = 1'b0;
        if (is_zero_c) begin
            out_data_d = {s2_sign_q, 20'h0};
        end else if (exp_r_c >= 10'sd255) begin
            out_data_d = {s2_sign_q, 8'hFF, 12'h000};
            out_ovf_d  = s2_valid_q;
        end else if (exp_r_c <= 10'sd0) begin
            out_data_d = {s2_sign_q, 20'h0};
            out_unf_d  = s2_valid_q;
        end
    end

    // Output register; flags only accompany a valid beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else if (in_ready) begin
            out_valid_q <= s2_valid_q;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
            if (s2_valid_q) out_data_q <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_fp21_normalize.sv
// Directed bench for fp21_normalize; expectations follow FP21_NORM_ROUND_EN.
module tb_fp21_normalize;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [14:0] in_mag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [20:0] out_data;
    logic        out_ovf;
    logic        out_unf;

    fp21_normalize dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mag    (in_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] mag;
        logic [7:0]  exp;
        logic        sign;
        logic [20:0] data;
        logic        ovf;
        logic        unf;
    } vec_t;

`ifdef FP21_NORM_ROUND_EN
    localparam logic [20:0] E_2003 = 21'h080002;
    localparam logic [20:0] E_4007 = 21'h081002;
    localparam logic [20:0] E_3FFF = 21'h081000;
    localparam logic [20:0] E_HI   = 21'h0FF000;
    localparam logic        O_HI   = 1'b1;
`else
    localparam logic [20:0] E_2003 = 21'h080001;
    localparam logic [20:0] E_4007 = 21'h081001;
    localparam logic [20:0] E_3FFF = 21'h080FFF;
    localparam logic [20:0] E_HI   = 21'h0FEFFF;
    localparam logic        O_HI   = 1'b0;
`endif

    localparam int NV = 15;
    vec_t vecs [NV];

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        in_sign = v.sign;
        in_exp  = v.exp;
        in_mag  = v.mag;
    endtask

    // One isolated transfer: check acceptance, latency, data and flags
    task automatic send_one(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(v);
        #1 chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},  32'(lat),      32'd3);
        chk({tag, "_data"}, 32'(out_data), 32'(v.data));
        chk({tag, "_ovf"},  32'(out_ovf),  32'(v.ovf));
        chk({tag, "_unf"},  32'(out_unf),  32'(v.unf));
    endtask

    initial begin
        vec_t e;
        vec_t exp_q [$];
        int   idx, got, extra, beats, first;
        bit   saw_stall;
        logic [20:0] first_data;

        vecs[0]  = '{15'h1000, 8'd127, 1'b0, 21'h07F000, 1'b0, 1'b0};
        vecs[1]  = '{15'h2003, 8'd127, 1'b0, E_2003,     1'b0, 1'b0};
        vecs[2]  = '{15'h0001, 8'd20,  1'b0, 21'h008000, 1'b0, 1'b0};
        vecs[3]  = '{15'h0001, 8'd12,  1'b1, 21'h100000, 1'b0, 1'b1};
        vecs[4]  = '{15'h4000, 8'd254, 1'b0, 21'h0FF000, 1'b1, 1'b0};
        vecs[5]  = '{15'h0000, 8'd100, 1'b0, 21'h000000, 1'b0, 1'b0};
        vecs[6]  = '{15'h0000, 8'd100, 1'b1, 21'h100000, 1'b0, 1'b0};
        vecs[7]  = '{15'h2001, 8'd127, 1'b0, 21'h080000, 1'b0, 1'b0};
        vecs[8]  = '{15'h4007, 8'd127, 1'b0, E_4007,     1'b0, 1'b0};
        vecs[9]  = '{15'h3FFF, 8'd127, 1'b0, E_3FFF,     1'b0, 1'b0};
        vecs[10] = '{15'h3FFF, 8'd253, 1'b0, E_HI,       O_HI, 1'b0};
        vecs[11] = '{15'h0123, 8'd130, 1'b1, 21'h17E230, 1'b0, 1'b0};
        vecs[12] = '{15'h2000, 8'd254, 1'b0, 21'h0FF000, 1'b1, 1'b0};
        vecs[13] = '{15'h0800, 8'd2,   1'b0, 21'h001000, 1'b0, 1'b0};
        vecs[14] = '{15'h4000, 8'd254, 1'b1, 21'h1FF000, 1'b1, 1'b0};

        // Reset state
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_flags", 32'({out_ovf, out_unf}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, one at a time
        for (int i = 0; i < NV; i++) send_one(vecs[i], $sformatf("v%0d", i));

        // Backpressure: 5 back-to-back inputs, out_ready low for 4 cycles
        idx = 0; got = 0; extra = 0; saw_stall = 1'b0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            if (idx < 5) begin
                in_valid = 1'b1;
                drive(vecs[idx]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("bp_data%0d", got), 32'(out_data), 32'(e.data));
                    chk($sformatf("bp_ovf%0d", got),  32'(out_ovf),  32'(e.ovf));
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(vecs[idx]);
                idx++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 if (out_valid) extra++;
            @(negedge clk);
        end
        chk("bp_count", 32'(got),       32'd5);
        chk("bp_extra", 32'(extra),     32'd0);
        chk("bp_stall", 32'(saw_stall), 32'd1);

        // Reset with three items in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive(vecs[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_data",  32'(out_data),  32'd0);
        chk("mid_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        drive(vecs[11]);
        #1 chk("post_ready", 32'(in_ready), 32'd1);
        beats = 0; first = 0; first_data = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                beats++;
                if (beats == 1) begin
                    first      = c;
                    first_data = out_data;
                end
            end
        end
        chk("post_beats", 32'(beats),      32'd1);
        chk("post_lat",   32'(first),      32'd3);
        chk("post_data",  32'(first_data), 32'(vecs[11].data));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
